// File: rtl/scan_ctrl_pkg.sv
// rtl/scan_ctrl_pkg.sv - FSM state type and MISR constants shared by scan_chain_ctrl and scan_misr
package scan_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHIFT   = 3'd1,
    CAPTURE = 3'd2,
    UNLOAD  = 3'd3,
    FIN     = 3'd4
  } scan_state_t;

  localparam int MISR_W = 16;
  localparam logic [MISR_W-1:0] MISR_POLY = 16'h1021;

  function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0] sig,
                                                  input logic din);
    logic fb;
    fb = sig[MISR_W-1] ^ din;
    return {sig[MISR_W-2:0], 1'b0} ^ (fb ? MISR_POLY : '0);
  endfunction

endpackage

// File: rtl/scan_misr.sv
// rtl/scan_misr.sv - serial-input MISR compacting the unloaded response stream
module scan_misr
  import scan_ctrl_pkg::*;
(
  input  logic              CLK,
  input  logic              RSTB,
  input  logic              clr,
  input  logic              en,
  input  logic              din,
  output logic [MISR_W-1:0] sig
);

  logic [MISR_W-1:0] sig_q, sig_d;

  // clear wins so a new pattern always starts from a zero seed
  always_comb begin
    sig_d = sig_q;
    if (clr) begin
      sig_d = '0;
    end else if (en) begin
      sig_d = misr_step(sig_q, din);
    end
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/scan_chain_ctrl.sv
// rtl/scan_chain_ctrl.sv - scan load/capture/unload sequencer; MISR signature only with SCAN_CTRL_MISR_EN
module scan_chain_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter  int CHAIN_MAX  = 64,
  parameter  int CAP_CYCLES = 1,
  localparam int LW         = $clog2(CHAIN_MAX + 1)
) (
  input  logic              CLK,
  input  logic              RSTB,
  input  logic              start,
  input  logic [LW-1:0]     len,
  input  logic              abort,
  input  logic              pat_valid,
  input  logic              pat_bit,
  output logic              pat_ready,
  output logic              se,
  output logic              si,
  output logic              chain_en,
  input  logic              so,
  output logic              resp_valid,
  output logic              resp_bit,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [MISR_W-1:0] signature
);

  localparam int CW = (CAP_CYCLES > 1) ? $clog2(CAP_CYCLES) : 1;

  scan_state_t   state_q, state_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] len_q, len_d;
  logic [CW-1:0] cap_q, cap_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          len_ok, start_acc, last_beat;

  assign len_ok    = (len != '0) && (len <= LW'(CHAIN_MAX));
  assign start_acc = (state_q == IDLE) && start && len_ok;
  assign last_beat = ((cnt_q + LW'(1)) == len_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    cap_d      = cap_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    se         = 1'b0;
    si         = 1'b0;
    chain_en   = 1'b0;
    pat_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_bit   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_acc) begin
          len_d   = len;
          cnt_d   = '0;
          cap_d   = '0;
          state_d = SHIFT;
        end else if (start) begin
          err_d = 1'b1;
        end
      end
      SHIFT: begin
        se        = 1'b1;
        pat_ready = 1'b1;
        si        = pat_bit;
        chain_en  = pat_valid;
        if (pat_valid) begin
          if (last_beat) begin
            cnt_d   = '0;
            state_d = CAPTURE;
          end else begin
            cnt_d = cnt_q + LW'(1);
          end
        end
      end
      CAPTURE: begin
        chain_en = 1'b1;
        if (cap_q == CW'(CAP_CYCLES - 1)) begin
          cap_d   = '0;
          state_d = UNLOAD;
        end else begin
          cap_d = cap_q + CW'(1);
        end
      end
      UNLOAD: begin
        se         = 1'b1;
        chain_en   = 1'b1;
        resp_valid = 1'b1;
        resp_bit   = so;
        if (last_beat) begin
          cnt_d   = '0;
          state_d = FIN;
        end else begin
          cnt_d = cnt_q + LW'(1);
        end
      end
      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // abort overrides any terminal beat decided above, including the done from FIN
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      cnt_d   = '0;
      cap_d   = '0;
      done_d  = 1'b0;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      cap_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      cap_q   <= cap_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign err  = err_q;

`ifdef SCAN_CTRL_MISR_EN
  scan_misr u_misr (
    .CLK  (CLK),
    .RSTB (RSTB),
    .clr  (start_acc),
    .en   (resp_valid),
    .din  (so),
    .sig  (signature)
  );
`else
  assign signature = '0;
`endif

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// tb/tb_scan_chain_ctrl.sv - bench for scan_chain_ctrl with a behavioural scan chain and response model
module tb_scan_chain_ctrl;

  localparam int CHAIN_MAX = 64;
  localparam int CAP       = 1;
  localparam int LW        = $clog2(CHAIN_MAX + 1);

  logic          CLK = 1'b0;
  logic          RSTB = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] len = '0;
  logic          abort = 1'b0;
  logic          pat_valid = 1'b0;
  logic          pat_bit = 1'b0;
  logic          pat_ready, se, si, chain_en, so;
  logic          resp_valid, resp_bit, busy, done, err;
  logic [15:0]   signature;

  int checks = 0;
  int failures = 0;

  logic [63:0] chain = '0;
  logic [63:0] dmask = '0;
  int          cur_len = 4;

  always #5 CLK = ~CLK;

  scan_chain_ctrl #(.CHAIN_MAX(CHAIN_MAX), .CAP_CYCLES(CAP)) dut (
    .CLK        (CLK),
    .RSTB       (RSTB),
    .start      (start),
    .len        (len),
    .abort      (abort),
    .pat_valid  (pat_valid),
    .pat_bit    (pat_bit),
    .pat_ready  (pat_ready),
    .se         (se),
    .si         (si),
    .chain_en   (chain_en),
    .so         (so),
    .resp_valid (resp_valid),
    .resp_bit   (resp_bit),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .signature  (signature)
  );

  // scan cells: shift si toward higher index; capture loads D = Q ^ dmask
  always @(posedge CLK) begin
    if (chain_en) chain <= se ? {chain[62:0], si} : (chain ^ dmask);
  end
  assign so = chain[cur_len-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // response bit k is load bit k XOR the capture mask of the cell it ended up in
  function automatic logic [63:0] model_resp(input int n, input logic [63:0] bits,
                                             input logic [63:0] mask);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < n; k++) r[k] = bits[k] ^ mask[n-1-k];
    return r;
  endfunction

  function automatic logic [15:0] model_sig(input int n, input logic [63:0] r);
    logic [15:0] s;
    s = '0;
    for (int k = 0; k < n; k++)
      s = (s[15] ^ r[k]) ? ({s[14:0], 1'b0} ^ 16'h1021) : {s[14:0], 1'b0};
    return s;
  endfunction

  task automatic run_pat(input int n_len, input logic [63:0] bits, input int gap_at,
                         input int gap_len, input int abort_c, input bit noise,
                         output int done_c, output int err_c, output int n_done,
                         output int n_err, output int n_busy, output int bad,
                         output logic [63:0] resp, output int n_resp);
    int bi;
    int term;
    done_c = -1; err_c = -1; n_done = 0; n_err = 0; n_busy = 0; bad = 0;
    resp = '0; n_resp = 0; bi = 0; term = -1;
    for (int c = 0; c < 400; c++) begin
      @(negedge CLK);
      if (c == 0) begin
        start = 1'b1;
        len   = LW'(n_len);
      end else begin
        start = noise && busy && ($urandom_range(0, 1) == 1);
        len   = LW'($urandom_range(1, CHAIN_MAX));
      end
      pat_valid = !(c >= gap_at && c < gap_at + gap_len);
      pat_bit   = (bi < 64) ? bits[bi] : 1'b0;
      abort     = (c == abort_c);
      #1;
      if (busy) n_busy++;
      if (pat_valid && pat_ready) bi++;
      if (resp_valid) begin
        if (n_resp < 64) resp[n_resp] = resp_bit;
        n_resp++;
      end
      if (done) begin n_done++; if (done_c < 0) done_c = c; end
      if (err)  begin n_err++;  if (err_c < 0)  err_c = c;  end
      if ((!busy && (se || chain_en || pat_ready || resp_valid)) || (err && busy) ||
          (!pat_valid && chain_en))
        bad++;
      if (term < 0 && (done || err)) term = c;
      if (term >= 0 && c >= term + 3) break;
    end
    start = 1'b0; abort = 1'b0; pat_valid = 1'b0;
  endtask

  typedef struct {
    int          n;
    logic [63:0] bits;
    logic [63:0] mask;
    int          gap_at;
    int          gap_len;
    int          abort_c;
    int          exp_done;
    int          exp_err;
    logic [63:0] exp_resp;
    bit          chk_sig;
    logic [15:0] exp_sig;
  } vec_t;

  initial begin
    vec_t        tbl[11];
    vec_t        t;
    int          dc, ec, nd, ne, nb, bad, nr, n, gl, ga;
    logic [63:0] resp, bits, expr;
    logic [15:0] exps;

    tbl[0]  = '{4, 64'hD, 64'h6, -10, 0, -1, 11, -1, 64'hB, 1'b0, 16'h0};
    tbl[1]  = '{4, 64'h6, 64'h0, 2, 3, -1, 14, -1, 64'h6, 1'b0, 16'h0};
    tbl[2]  = '{0, 64'h0, 64'h0, -10, 0, -1, -1, 1, 64'h0, 1'b0, 16'h0};
    tbl[3]  = '{65, 64'h0, 64'h0, -10, 0, -1, -1, 1, 64'h0, 1'b0, 16'h0};
    tbl[4]  = '{4, 64'h5, 64'h0, -10, 0, 7, -1, 8, 64'h0, 1'b0, 16'h0};
    tbl[5]  = '{4, 64'h5, 64'h0, -10, 0, 9, -1, 10, 64'h0, 1'b0, 16'h0};
    tbl[6]  = '{4, 64'h5, 64'h0, -10, 0, 4, -1, 5, 64'h0, 1'b0, 16'h0};
    tbl[7]  = '{1, 64'h1, 64'h0, -10, 0, -1, 5, -1, 64'h1, 1'b1, 16'h1021};
    tbl[8]  = '{8, 64'h0, 64'h0, -10, 0, -1, 19, -1, 64'h0, 1'b1, 16'h0000};
    tbl[9]  = '{64, 64'hDEADBEEF01234567, 64'h0, -10, 0, -1, 131, -1,
                64'hDEADBEEF01234567, 1'b0, 16'h0};
    tbl[10] = '{4, 64'h5, 64'h0, -10, 0, 10, -1, 11, 64'h0, 1'b0, 16'h0};

    repeat (2) @(negedge CLK);
    #1;
    chk("reset_outputs", {se, si, chain_en, pat_ready, resp_valid, resp_bit, busy, done, err,
                          signature}, '0);
    @(negedge CLK);
    RSTB = 1'b1;

    @(negedge CLK);
    abort = 1'b1;
    #1;
    @(negedge CLK);
    abort = 1'b0;
    #1;
    chk("abort_idle_noeffect", {err, busy, done}, '0);

    for (int i = 0; i < 11; i++) begin
      t       = tbl[i];
      cur_len = (t.n >= 1 && t.n <= CHAIN_MAX) ? t.n : 1;
      dmask   = t.mask;
      run_pat(t.n, t.bits, t.gap_at, t.gap_len, t.abort_c, 1'b0, dc, ec, nd, ne, nb, bad, resp, nr);
      chk($sformatf("row%0d_done_cycle", i), dc, t.exp_done);
      chk($sformatf("row%0d_err_cycle", i), ec, t.exp_err);
      chk($sformatf("row%0d_pulse_count", i), nd + ne, 1);
      chk($sformatf("row%0d_enable_rules", i), bad, 0);
      if (t.exp_done < 0 && t.abort_c < 0) chk($sformatf("row%0d_never_busy", i), nb, 0);
      if (t.exp_done >= 0) begin
        chk($sformatf("row%0d_resp_count", i), nr, t.n);
        chk($sformatf("row%0d_resp_bits", i), resp, t.exp_resp);
`ifdef SCAN_CTRL_MISR_EN
        exps = t.chk_sig ? t.exp_sig : model_sig(t.n, t.exp_resp);
`else
        exps = 16'h0000;
`endif
        chk($sformatf("row%0d_signature", i), signature, exps);
      end
    end

    // reset during CAPTURE, then a fresh pattern must complete normally
    cur_len = 4;
    dmask   = 64'h6;
    @(negedge CLK);
    start = 1'b1; len = LW'(4); pat_valid = 1'b1; pat_bit = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge CLK);
      start = 1'b0;
    end
    #1;
    chk("in_capture_before_reset", {busy, se, chain_en}, 3'b101);
    #1;
    RSTB = 1'b0;
    #1;
    chk("reset_midpattern_outputs", {se, si, chain_en, pat_ready, resp_valid, resp_bit, busy,
                                     done, err, signature}, '0);
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      #1;
      chk($sformatf("reset_hold_%0d", c), {done, err, busy}, '0);
    end
    @(negedge CLK);
    RSTB = 1'b1;
    pat_valid = 1'b0;
    run_pat(4, 64'hD, -10, 0, -1, 1'b0, dc, ec, nd, ne, nb, bad, resp, nr);
    chk("after_reset_done_cycle", dc, 11);
    chk("after_reset_no_err", ne, 0);
    chk("after_reset_resp", resp, 64'hB);

    // random patterns with stalls and ignored starts against the model
    for (int r = 0; r < 20; r++) begin
      n       = $urandom_range(1, 16);
      gl      = $urandom_range(0, 3);
      ga      = $urandom_range(1, n);
      bits    = {$urandom, $urandom};
      dmask   = {$urandom, $urandom};
      cur_len = n;
      run_pat(n, bits, ga, gl, -1, 1'b1, dc, ec, nd, ne, nb, bad, resp, nr);
      expr = model_resp(n, bits, dmask);
      chk($sformatf("rand%0d_done_cycle", r), dc, 2 * n + CAP + 2 + gl);
      chk($sformatf("rand%0d_err", r), ne, 0);
      chk($sformatf("rand%0d_enable_rules", r), bad, 0);
      chk($sformatf("rand%0d_resp", r), {nr, resp}, {n, expr});
`ifdef SCAN_CTRL_MISR_EN
      exps = model_sig(n, expr);
`else
      exps = 16'h0000;
`endif
      chk($sformatf("rand%0d_signature", r), signature, exps);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
